// File: rtl/uart_mmio_if.sv
// Memory-mapped bus port of the UART: decoder select, store strobe, address and data.
interface uart_mmio_if;
    logic        uart_sel;
    logic        uart_write;
    logic [15:0] uart_addr;
    logic [31:0] uart_wdata;
    logic [31:0] uart_rdata;

    modport master (
        output uart_sel, uart_write, uart_addr, uart_wdata,
        input  uart_rdata
    );

    modport slave (
        input  uart_sel, uart_write, uart_addr, uart_wdata,
        output uart_rdata
    );
endinterface

// File: rtl/uart_mmio.sv
// 8N1 UART with a four-word MMIO register map: TXDATA, RXDATA, STATUS (W1C ovr/ferr), reserved.
module uart_mmio #(
    parameter int CLOCK_FREQ   = 125_000_000,
    parameter int BAUD_RATE    = 115_200,
    parameter int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE
) (
    input  logic       clk,
    input  logic       n_rst,
    uart_mmio_if.slave bus,
    input  logic       UART_RXD,
    output logic       UART_TXD
);
    localparam int             CW   = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  MID  = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // Bus decode
    logic [1:0] reg_sel;
    logic       wr_en, tx_wr, st_wr, rx_rd;
    logic       unused_bits;

    assign reg_sel     = bus.uart_addr[3:2];
    assign wr_en       = bus.uart_sel & bus.uart_write;
    assign tx_wr       = wr_en & (reg_sel == 2'd0);
    assign st_wr       = wr_en & (reg_sel == 2'd2);
    assign rx_rd       = bus.uart_sel & ~bus.uart_write & (reg_sel == 2'd1);
    assign unused_bits = ^{bus.uart_addr[15:4], bus.uart_addr[1:0], bus.uart_wdata[31:8]};

    // ---------------- Transmitter ----------------
    tx_state_t     tx_state, tx_next;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shreg;
    logic          tx_tick, tx_busy;

    assign tx_tick = (tx_cnt == LAST);
    assign tx_busy = (tx_state != TX_IDLE);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) tx_state <= TX_IDLE;
        else        tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE:  if (tx_wr) tx_next = TX_START;
            TX_START: if (tx_tick) tx_next = TX_DATA;
            TX_DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = TX_STOP;
            TX_STOP:  if (tx_tick) tx_next = TX_IDLE;
            default:  tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shreg <= '0;
        end else if (tx_state == TX_IDLE) begin
            tx_cnt <= '0;
            tx_bit <= '0;
            if (tx_wr) tx_shreg <= bus.uart_wdata[7:0];
        end else if (tx_tick) begin
            tx_cnt <= '0;
            if (tx_state == TX_DATA) begin
                tx_shreg <= {1'b0, tx_shreg[7:1]};
                tx_bit   <= tx_bit + 3'd1;
            end
        end else begin
            tx_cnt <= tx_cnt + 1'b1;
        end
    end

    always_comb begin
        case (tx_state)
            TX_START: UART_TXD = 1'b0;
            TX_DATA:  UART_TXD = tx_shreg[0];
            default:  UART_TXD = 1'b1;
        endcase
    end

    // ---------------- Receiver ----------------
    rx_state_t     rx_state, rx_next;
    logic [1:0]    rx_sync;
    logic          rxs;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shreg;
    logic          rx_tick, rx_mid, rx_done;
    logic [7:0]    rx_data;
    logic          rx_valid, ovr, ferr;

    assign rxs     = rx_sync[1];
    assign rx_tick = (rx_cnt == LAST);
    assign rx_mid  = (rx_cnt == MID);
    assign rx_done = (rx_state == RX_STOP) && rx_tick;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) rx_sync <= '1;
        else        rx_sync <= {rx_sync[0], UART_RXD};
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) rx_state <= RX_IDLE;
        else        rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (!rxs) rx_next = RX_START;
            RX_START: if (rx_mid) rx_next = rxs ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (rx_tick) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shreg <= '0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    rx_bit <= '0;
                end
                RX_START: rx_cnt <= rx_mid ? '0 : rx_cnt + 1'b1;
                RX_DATA: begin
                    if (rx_tick) begin
                        rx_cnt   <= '0;
                        rx_shreg <= {rxs, rx_shreg[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_cnt <= rx_tick ? '0 : rx_cnt + 1'b1;
            endcase
        end
    end

    // A completing byte takes priority over a same-edge read or W1C clear.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            ovr      <= 1'b0;
            ferr     <= 1'b0;
        end else begin
            if (rx_done && rxs) begin
                rx_data  <= rx_shreg;
                rx_valid <= 1'b1;
            end else if (rx_rd) begin
                rx_valid <= 1'b0;
            end

            if (rx_done && rxs && rx_valid && !rx_rd) ovr <= 1'b1;
            else if (st_wr && bus.uart_wdata[2])      ovr <= 1'b0;

            if (rx_done && !rxs)                 ferr <= 1'b1;
            else if (st_wr && bus.uart_wdata[3]) ferr <= 1'b0;
        end
    end

    always_comb begin
        bus.uart_rdata = '0;
        if (bus.uart_sel) begin
            case (reg_sel)
                2'd1:    bus.uart_rdata = {24'd0, rx_data};
                2'd2:    bus.uart_rdata = {28'd0, ferr, ovr, rx_valid, tx_busy};
                default: bus.uart_rdata = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_mmio.sv
// Self-checking bench for uart_mmio at 8 clocks per bit: directed tables, corner sequences, random TX/RX traffic.
module tb_uart_mmio;
    localparam int CPB = 8;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    logic rxd   = 1'b1;
    logic txd;

    uart_mmio_if bus();

    uart_mmio #(
        .CLOCK_FREQ  (80_000_000),
        .BAUD_RATE   (10_000_000),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk     (clk),
        .n_rst   (n_rst),
        .bus     (bus),
        .UART_RXD(rxd),
        .UART_TXD(txd)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int lat    = 0;

    // Reference RX register state, updated from the frame-level rules
    logic       m_valid = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0;
    logic [7:0] m_data  = 8'h00;

    typedef struct {
        bit          wr;
        logic        sel;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        bus.uart_sel   = 1'b0;
        bus.uart_write = 1'b0;
        bus.uart_addr  = '0;
        bus.uart_wdata = '0;
    endtask

    task automatic bus_status_view();
        bus.uart_sel   = 1'b1;
        bus.uart_write = 1'b0;
        bus.uart_addr  = 16'h0008;
    endtask

    // Combinational look at a register with no rising edge under the select
    task automatic peek(input logic [15:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.uart_sel   = 1'b1;
        bus.uart_write = 1'b0;
        bus.uart_addr  = a;
        #1 d = bus.uart_rdata;
        bus_idle();
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.uart_sel   = 1'b1;
        bus.uart_write = 1'b1;
        bus.uart_addr  = a;
        bus.uart_wdata = d;
        @(posedge clk);
        #1 bus_idle();
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.uart_sel   = 1'b1;
        bus.uart_write = 1'b0;
        bus.uart_addr  = a;
        #1 d = bus.uart_rdata;
        @(posedge clk);
        #1 bus_idle();
    endtask

    task automatic tx_frame_check(input logic [7:0] data, input bit inject);
        logic [9:0] fr;
        fr = {1'b1, data, 1'b0};
        @(negedge clk);
        bus.uart_sel   = 1'b1;
        bus.uart_write = 1'b1;
        bus.uart_addr  = 16'h0000;
        bus.uart_wdata = {24'd0, data};
        @(posedge clk);
        #1 bus_status_view();
        for (int i = 0; i < 10 * CPB; i++) begin
            @(negedge clk);
            if (inject && i == 1) begin
                bus.uart_write = 1'b1;
                bus.uart_addr  = 16'h0000;
                bus.uart_wdata = 32'h0000_0042;
            end
            if (inject && i == 2) bus_status_view();
            #1 check("tx_line", {31'd0, txd}, {31'd0, fr[i / CPB]});
            if (!(inject && i == 1)) check("tx_busy", {31'd0, bus.uart_rdata[0]}, 32'd1);
        end
        @(negedge clk);
        #1 check("tx_idle_line", {31'd0, txd}, 32'd1);
        check("tx_busy_done", {31'd0, bus.uart_rdata[0]}, 32'd0);
        bus_idle();
    endtask

    // Caller starts this on a falling clock edge
    task automatic send_rx(input logic [7:0] d, input logic stop);
        logic [9:0] fr;
        fr = {stop, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            rxd = fr[b];
            repeat (CPB) @(negedge clk);
        end
        rxd = 1'b1;
    endtask

    task automatic rx_frame(input logic [7:0] d, input logic stop);
        @(negedge clk);
        send_rx(d, stop);
        repeat (4) @(negedge clk);
    endtask

    task automatic expect_reg(input string name, input logic [15:0] a, input logic [31:0] exp);
        logic [31:0] v;
        peek(a, v);
        check(name, v, exp);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] v;
        bus_idle();

        // Reset values, observed while reset is still held
        #23;
        check("rst_txd", {31'd0, txd}, 32'd1);
        bus_status_view();
        #1 check("rst_status", bus.uart_rdata, 32'd0);
        bus.uart_addr = 16'h0004;
        #1 check("rst_rxdata", bus.uart_rdata, 32'd0);
        bus_idle();
        @(negedge clk);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        // TX 0xA5 frame, then a second write dropped while busy
        tx_frame_check(8'hA5, 1'b0);
        expect_reg("tx_status_after", 16'h0008, 32'd0);
        tx_frame_check(8'h41, 1'b1);
        repeat (CPB) @(negedge clk);
        check("tx_drop_line", {31'd0, txd}, 32'd1);
        expect_reg("tx_drop_status", 16'h0008, 32'd0);

        // RX 0x3C, measuring the edge at which rx_valid rises
        @(negedge clk);
        fork
            send_rx(8'h3C, 1'b1);
            begin
                bus_status_view();
                for (int c = 1; c <= 200; c++) begin
                    @(posedge clk);
                    #1;
                    if (bus.uart_rdata[1]) begin
                        lat = c;
                        break;
                    end
                end
                bus_idle();
            end
        join
        repeat (4) @(negedge clk);
        check("rx_latency_found", {31'd0, lat > 0}, 32'd1);
        if (lat == 0) lat = 10 * CPB - 1;
        expect_reg("rx_status_valid", 16'h0008, 32'h2);
        bus_read(16'h0004, v);
        check("rx_read_3c", v, 32'h3C);
        expect_reg("rx_status_cleared", 16'h0008, 32'h0);

        // Read coinciding with completion: new byte wins, no overrun
        rx_frame(8'h5E, 1'b1);
        @(negedge clk);
        fork
            send_rx(8'hC3, 1'b1);
            begin
                repeat (lat - 1) @(posedge clk);
                #1;
                bus.uart_sel   = 1'b1;
                bus.uart_write = 1'b0;
                bus.uart_addr  = 16'h0004;
                #1 check("coinc_read_old", bus.uart_rdata, 32'h5E);
                @(posedge clk);
                #1 bus_idle();
            end
        join
        repeat (4) @(negedge clk);
        expect_reg("coinc_status", 16'h0008, 32'h2);
        expect_reg("coinc_rxdata", 16'h0004, 32'hC3);

        // W1C of ovr coinciding with an overrun: ovr stays set
        @(negedge clk);
        fork
            send_rx(8'h77, 1'b1);
            begin
                repeat (lat - 1) @(posedge clk);
                #1;
                bus.uart_sel   = 1'b1;
                bus.uart_write = 1'b1;
                bus.uart_addr  = 16'h0008;
                bus.uart_wdata = 32'h4;
                @(posedge clk);
                #1 bus_idle();
            end
        join
        repeat (4) @(negedge clk);
        expect_reg("w1c_coinc_status", 16'h0008, 32'h6);
        bus_write(16'h0008, 32'hC);
        expect_reg("w1c_clear_status", 16'h0008, 32'h2);
        bus_read(16'h0004, v);
        check("w1c_read_77", v, 32'h77);

        // Two frames, no read: overrun, then W1C of ovr
        rx_frame(8'h11, 1'b1);
        rx_frame(8'h22, 1'b1);
        expect_reg("ovr_status", 16'h0008, 32'h6);
        expect_reg("ovr_rxdata", 16'h0004, 32'h22);
        bus_write(16'h0008, 32'h4);
        expect_reg("ovr_w1c_status", 16'h0008, 32'h2);

        // Register map / decode table (state: rx_valid=1, rx_data=0x22)
        tbl[0]  = '{0, 1'b1, 16'h0000, 32'h0,         32'h0};
        tbl[1]  = '{0, 1'b1, 16'h0004, 32'h0,         32'h22};
        tbl[2]  = '{0, 1'b1, 16'h0008, 32'h0,         32'h2};
        tbl[3]  = '{0, 1'b1, 16'h000C, 32'h0,         32'h0};
        tbl[4]  = '{0, 1'b0, 16'h0004, 32'h0,         32'h0};
        tbl[5]  = '{0, 1'b0, 16'h0008, 32'h0,         32'h0};
        tbl[6]  = '{0, 1'b1, 16'hFFF4, 32'h0,         32'h22};
        tbl[7]  = '{0, 1'b1, 16'h000B, 32'h0,         32'h2};
        tbl[8]  = '{1, 1'b1, 16'hFFFC, 32'hFFFF_FFFF, 32'h0};
        tbl[9]  = '{0, 1'b1, 16'h0008, 32'h0,         32'h2};
        tbl[10] = '{1, 1'b1, 16'h0008, 32'h0000_0003, 32'h0};
        tbl[11] = '{0, 1'b1, 16'h0004, 32'h0,         32'h22};
        for (int k = 0; k < 12; k++) begin
            if (tbl[k].wr) begin
                bus_write(tbl[k].addr, tbl[k].wdata);
            end else begin
                @(negedge clk);
                bus.uart_sel   = tbl[k].sel;
                bus.uart_write = 1'b0;
                bus.uart_addr  = tbl[k].addr;
                #1 check($sformatf("table_%0d", k), bus.uart_rdata, tbl[k].exp);
                bus_idle();
            end
        end
        bus_read(16'h0004, v);
        check("table_read_22", v, 32'h22);
        expect_reg("table_status_after", 16'h0008, 32'h0);

        // Short low glitch is rejected; a bad stop bit sets only ferr
        @(negedge clk);
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        repeat (5 * CPB) @(negedge clk);
        expect_reg("glitch_status", 16'h0008, 32'h0);
        rx_frame(8'hAB, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        expect_reg("ferr_status", 16'h0008, 32'h8);
        expect_reg("ferr_rxdata", 16'h0004, 32'h22);

        // Asynchronous reset during TX data bit 3 (0x96 bit3 = 0)
        @(negedge clk);
        bus.uart_sel   = 1'b1;
        bus.uart_write = 1'b1;
        bus.uart_addr  = 16'h0000;
        bus.uart_wdata = 32'h96;
        @(posedge clk);
        #1 bus_idle();
        repeat (36) @(negedge clk);
        #1 check("prereset_bit3", {31'd0, txd}, 32'd0);
        #1 n_rst = 1'b0;
        #1 check("async_rst_txd", {31'd0, txd}, 32'd1);
        bus_status_view();
        #1 check("async_rst_status", bus.uart_rdata, 32'd0);
        bus_idle();
        @(negedge clk);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        tx_frame_check(8'h5A, 1'b0);

        // Random simultaneous TX/RX traffic against the frame-level model
        m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_data = 8'h00;
        for (int it = 0; it < 8; it++) begin
            logic [7:0] tb_byte, rb_byte;
            logic       stop;
            int         act;
            logic [3:0] w;
            tb_byte = 8'($urandom_range(0, 255));
            rb_byte = 8'($urandom_range(0, 255));
            stop    = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            fork
                tx_frame_check(tb_byte, 1'b0);
                send_rx(rb_byte, stop);
            join
            repeat (3) @(negedge clk);
            if (stop) begin
                if (m_valid) m_ovr = 1'b1;
                m_valid = 1'b1;
                m_data  = rb_byte;
            end else begin
                m_ferr = 1'b1;
            end
            expect_reg("rand_status", 16'h0008, {28'd0, m_ferr, m_ovr, m_valid, 1'b0});
            expect_reg("rand_rxdata", 16'h0004, {24'd0, m_data});
            act = $urandom_range(0, 2);
            if (act == 0) begin
                bus_read(16'h0004, v);
                check("rand_read", v, {24'd0, m_data});
                m_valid = 1'b0;
            end else if (act == 1) begin
                w = 4'($urandom_range(0, 15));
                bus_write(16'h0008, {28'd0, w});
                if (w[2]) m_ovr = 1'b0;
                if (w[3]) m_ferr = 1'b0;
            end
            repeat (CPB) @(negedge clk);
        end
        expect_reg("rand_final_status", 16'h0008, {28'd0, m_ferr, m_ovr, m_valid, 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_mmio.md
UART_MMIO -- requirements
Module: uart_mmio

Interface
REQ-001 The module SHALL have parameter CLOCK_FREQ, default 125_000_000, meaning the clk frequency in Hz.
REQ-002 The module SHALL have parameter BAUD_RATE, default 115_200, meaning the serial bit rate.
REQ-003 The module SHALL have parameter CLKS_PER_BIT, default CLOCK_FREQ/BAUD_RATE (1085), meaning clk cycles per serial bit; it SHALL be overridable and legal for any value >= 4.
REQ-004 The module SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-005 The module SHALL have port n_rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The module SHALL have port uart_sel, input, 1 bit: bus select, high when the decoder maps the current data address to the UART.
REQ-007 The module SHALL have port uart_write, input, 1 bit: store strobe, qualified by uart_sel.
REQ-008 The module SHALL have port uart_addr, input, 16 bits: byte address; only bits [3:2] are decoded.
REQ-009 The module SHALL have port uart_wdata, input, 32 bits: store data; only bits [7:0] are used.
REQ-010 The module SHALL have port uart_rdata, output, 32 bits: combinational read data.
REQ-011 The module SHALL have port UART_RXD, input, 1 bit: asynchronous serial input, idle high.
REQ-012 The module SHALL have port UART_TXD, output, 1 bit: serial output, idle high.

Function
REQ-013 Register map, by uart_addr[3:2]: 0 = TXDATA (W); 1 = RXDATA (R, {24'd0, rx_data}); 2 = STATUS (R: {28'd0, ferr, ovr, rx_valid, tx_busy}; W: write-1-to-clear of bit2 ovr and bit3 ferr); 3 = reads 0, writes ignored.
REQ-014 uart_rdata SHALL be combinational from uart_sel, uart_addr and state, and SHALL equal 0 whenever uart_sel is low.
REQ-015 A write is the condition uart_sel & uart_write at a rising edge; a read is uart_sel & ~uart_write with uart_addr[3:2]==1 at a rising edge.
REQ-016 TX FSM states SHALL be IDLE, START, DATA, STOP; a TXDATA write in IDLE latches uart_wdata[7:0] and enters START on that edge.
REQ-017 UART_TXD SHALL be driven low from the cycle after the write for exactly CLKS_PER_BIT cycles, then bits 0..7 LSB first for CLKS_PER_BIT cycles each, then high for CLKS_PER_BIT cycles (STOP), then return to IDLE.
REQ-018 tx_busy SHALL be high in every state other than IDLE; a TXDATA write while tx_busy is high SHALL be dropped with no state change.
REQ-019 UART_RXD SHALL pass through a two-flop synchronizer before any use; all RX timing is relative to the synchronized signal.
REQ-020 RX FSM states SHALL be IDLE, START, DATA, STOP; IDLE moves to START on a synchronized low level.
REQ-021 START SHALL resample at CLKS_PER_BIT/2 cycles; if the sample is high (glitch), the FSM SHALL return to IDLE with no flag change; if low, it SHALL enter DATA.
REQ-022 DATA SHALL sample 8 bits at CLKS_PER_BIT intervals, shifting LSB first; STOP SHALL sample once more after CLKS_PER_BIT cycles, then return to IDLE.
REQ-023 A stop sample of 1 SHALL load rx_data and set rx_valid; if rx_valid was already 1 and not being read in the same cycle, ovr SHALL be set and rx_data overwritten.
REQ-024 A stop sample of 0 SHALL set ferr and leave rx_data and rx_valid unchanged.
REQ-025 An RXDATA read SHALL clear rx_valid on that edge; if a byte completes on the same edge, the completion wins, so rx_valid stays 1, rx_data takes the new byte, and ovr is not set.
REQ-026 A STATUS W1C write coinciding with a flag-setting event SHALL leave the flag set.
REQ-027 The TX and RX paths SHALL be fully independent, including during simultaneous traffic.

Reset
REQ-028 On n_rst low, immediately and regardless of clk: both FSMs SHALL go to IDLE, UART_TXD SHALL be 1, rx_valid/ovr/ferr SHALL be 0, rx_data SHALL be 0, all counters 0, and synchronizer flops 1.
REQ-029 Reset mid-frame SHALL abort the frame; after release, the first TXDATA write SHALL transmit normally, and RX SHALL wait for a fresh falling edge.

Verification (CLKS_PER_BIT=8)
REQ-030 Write TXDATA 0x000000A5 -> UART_TXD low 8 cycles, then 1,0,1,0,0,1,0,1 at 8 cycles each, then high 8 cycles; tx_busy high for 80 cycles; STATUS[0] then reads 0.
REQ-031 Write 0x41 then 0x42 two cycles later -> only 0x41 is serialized; 0x42 is dropped.
REQ-032 Drive RX frame 0x3C -> STATUS reads 0x2 and RXDATA reads 0x3C; after that read, STATUS reads 0x0.
REQ-033 Drive RX frames 0x11 then 0x22 with no read in between -> RXDATA 0x22, STATUS 0x6; write STATUS 0x4 -> STATUS 0x2.
REQ-034 Drive RX with a 3-cycle low pulse -> no flags set; a frame with stop bit 0 -> STATUS bit3 set, rx_valid 0.
REQ-035 Assert n_rst low mid-TX at bit 3 -> UART_TXD 1 and STATUS 0 asynchronously; a following write of 0x5A transmits a correct frame.
